// File: rtl/rt_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// rt_fetch_ctrl
//
// Purpose:
//   Sequencer between the ray tracer's start/end control and the
//   ray/triangle intersector. A start pulse makes it do the following:
//     - fetch one ray, a triangle count and then each triangle over a
//       16-bit Avalon-MM read master;
//     - pack pairs of half-words into 32-bit words;
//     - hand each triangle to the intersector over valid/ready;
//     - keep the closest positive hit.
//
// Scene record layout (byte addresses relative to base_addr):
//   0x00 : ray, 6 words (origin xyz, dir xyz), 12 half-words
//   0x18 : triangle count, 2 half-words (bits above IDX_W ignored)
//   0x1C : triangle i at 0x1C + 0x24*i, 9 words (v0, v1, v2), 18 half-words
//   The record is contiguous, so the read address only ever advances by 2.
//
// Ports:
//   clk, reset              system clock, asynchronous active-low reset
//   start_rt, base_addr     start pulse and scene address, sampled in IDLE
//   busy, end_rt            run in progress / one-cycle completion pulse
//   o_hit, o_t, o_tri_index closest hit result (o_t signed Q16.16)
//   avm_m0_*                16-bit Avalon-MM read master, one read in flight
//   ray_o, tri_o            packed ray (6 words) and triangle (9 words),
//                           word k at bits [32k+31:32k]
//   tri_valid, tri_ready    triangle handshake towards the intersector
//   isect_valid/hit/t       intersector result strobe
//   perf_stall              stall counter (only counts when enabled)
//
// Configuration:
//   RT_FETCH_PERF_EN  when defined, perf_stall counts these cycles:
//     - Avalon cycles with read && waitrequest;
//     - ISSUE cycles with tri_ready low.
//   The counter clears on an accepted start and saturates at all-ones.
//   When undefined, perf_stall is tied to zero.
// -----------------------------------------------------------------------------
module rt_fetch_ctrl #(
    parameter int          ADDR_W = 32,
    parameter int          IDX_W  = 16,
    parameter logic [31:0] T_INIT = 32'h7FFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_rt,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              end_rt,
    output logic              o_hit,
    output logic [31:0]       o_t,
    output logic [IDX_W-1:0]  o_tri_index,
    output logic              avm_m0_read,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic [1:0]        avm_m0_byteenable,
    input  logic              avm_m0_waitrequest,
    input  logic [15:0]       avm_m0_readdata,
    input  logic              avm_m0_readdatavalid,
    output logic [191:0]      ray_o,
    output logic [287:0]      tri_o,
    output logic              tri_valid,
    input  logic              tri_ready,
    input  logic              isect_valid,
    input  logic              isect_hit,
    input  logic [31:0]       isect_t,
    output logic [31:0]       perf_stall
);

    // Last beat index (beats - 1) of each fetch phase.
    localparam logic [4:0] RAY_LAST = 5'd11;
    localparam logic [4:0] CNT_LAST = 5'd1;
    localparam logic [4:0] TRI_LAST = 5'd17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_RAY,
        S_RD_CNT,
        S_RD_TRI,
        S_ISSUE,
        S_WAIT_ISECT,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic               rd_wait_q;  // read accepted, waiting for readdatavalid
    logic [4:0]         beat_q;     // beat index within the current phase
    logic [15:0]        cnt_lo_q;   // low half of the count word
    logic [IDX_W-1:0]   count_q;    // triangles in the scene
    logic [IDX_W-1:0]   tri_idx_q;  // triangle currently being processed

    logic               start_acc;
    logic               beat_done;
    logic               last_beat;
    logic [4:0]         last_idx;
    logic [IDX_W-1:0]   cnt_new;
    logic               last_tri;
    logic               better;
    logic               next_is_rd;
    logic               issue_rd;

    assign avm_m0_byteenable = 2'b11;

    // Start is only honoured in IDLE; a pulse while busy is dropped.
    assign start_acc = (state_q == S_IDLE) && start_rt;

    // rd_wait_q is cleared by reset, so a late readdatavalid from a read
    // that was in flight at reset never lands in the datapath.
    assign beat_done = rd_wait_q && avm_m0_readdatavalid;
    assign last_beat = beat_done && (beat_q == last_idx);

    // Full count formed on its second beat, so the zero test does not
    // need an extra cycle. Upper count bits beyond IDX_W are dropped here.
    assign cnt_new  = IDX_W'({avm_m0_readdata, cnt_lo_q});
    assign last_tri = (tri_idx_q == count_q - IDX_W'(1));

    // Strictly closer and strictly positive; an equal t keeps the earlier
    // triangle.
    assign better = isect_hit
                 && ($signed(isect_t) > 32'sd0)
                 && ($signed(isect_t) < $signed(o_t));

    always_comb begin
        last_idx = TRI_LAST;
        case (state_q)
            S_RD_RAY: last_idx = RAY_LAST;
            S_RD_CNT: last_idx = CNT_LAST;
            default:  last_idx = TRI_LAST;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignment for every register, so all
            // flops update together from pre-edge values.
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path can leave one unassigned and infer a latch.
        state_d   = state_q;
        busy      = 1'b0;
        end_rt    = 1'b0;
        tri_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_rt) state_d = S_RD_RAY;
            end
            S_RD_RAY: begin
                busy = 1'b1;
                if (last_beat) state_d = S_RD_CNT;
            end
            S_RD_CNT: begin
                busy = 1'b1;
                if (last_beat) state_d = (cnt_new == '0) ? S_DONE : S_RD_TRI;
            end
            S_RD_TRI: begin
                busy = 1'b1;
                if (last_beat) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                tri_valid = 1'b1;
                if (tri_ready) state_d = S_WAIT_ISECT;
            end
            S_WAIT_ISECT: begin
                busy = 1'b1;
                if (isect_valid) state_d = last_tri ? S_DONE : S_RD_TRI;
            end
            S_DONE: begin
                end_rt  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new read request is raised in two cases:
    //   - when entering a fetch phase;
    //   - after a beat completes and the FSM stays in, or moves to,
    //     another fetch phase.
    assign next_is_rd = (state_d == S_RD_RAY) || (state_d == S_RD_CNT)
                     || (state_d == S_RD_TRI);
    assign issue_rd   = next_is_rd && (beat_done || (state_d != state_q));

    // ------------------------------------------------------------------
    // Read master, beat assembly and best-hit tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the ray/triangle buffers are plain registers driving
            // output ports, so they are reset along with everything else
            // and read as zero out of reset.
            avm_m0_read    <= 1'b0;
            avm_m0_address <= '0;
            rd_wait_q      <= 1'b0;
            beat_q         <= '0;
            cnt_lo_q       <= '0;
            count_q        <= '0;
            tri_idx_q      <= '0;
            ray_o          <= '0;
            tri_o          <= '0;
            o_hit          <= 1'b0;
            o_t            <= T_INIT;
            o_tri_index    <= '0;
        end else begin
            // Request held until the slave stops stalling, then dropped
            // while the single outstanding read completes.
            if (avm_m0_read && !avm_m0_waitrequest) begin
                avm_m0_read <= 1'b0;
                rd_wait_q   <= 1'b1;
            end

            if (beat_done) begin
                rd_wait_q      <= 1'b0;
                avm_m0_address <= avm_m0_address + ADDR_W'(2);
                beat_q         <= last_beat ? 5'd0 : beat_q + 5'd1;
                // Beats shift in from the top: after the last beat the first
                // half-word sits in [15:0], so even beats fill word low
                // halves and odd beats the high halves.
                case (state_q)
                    S_RD_RAY: ray_o <= {avm_m0_readdata, ray_o[191:16]};
                    S_RD_CNT: begin
                        if (beat_q == 5'd0) cnt_lo_q <= avm_m0_readdata;
                        else                count_q  <= cnt_new;
                    end
                    S_RD_TRI: tri_o <= {avm_m0_readdata, tri_o[287:16]};
                    default: ;
                endcase
            end

            if (issue_rd) avm_m0_read <= 1'b1;

            if (state_q == S_WAIT_ISECT && isect_valid) begin
                if (better) begin
                    o_hit       <= 1'b1;
                    o_t         <= isect_t;
                    o_tri_index <= tri_idx_q;
                end
                if (!last_tri) tri_idx_q <= tri_idx_q + IDX_W'(1);
            end

            if (start_acc) begin
                avm_m0_address <= base_addr;
                rd_wait_q      <= 1'b0;
                beat_q         <= '0;
                tri_idx_q      <= '0;
                o_hit          <= 1'b0;
                o_t            <= T_INIT;
                o_tri_index    <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional stall counter
    // ------------------------------------------------------------------
`ifdef RT_FETCH_PERF_EN
    logic [31:0] perf_q;
    logic        stall_ev;

    assign stall_ev = (avm_m0_read && avm_m0_waitrequest)
                   || (state_q == S_ISSUE && !tri_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (stall_ev && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall = perf_q;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_rt_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rt_fetch_ctrl
//
// Directed bench for rt_fetch_ctrl. The bench has three parts:
//   - a negedge process that plays a 16-bit Avalon slave with fixed
//     one-cycle read latency and an intersector with a fixed result table;
//   - scenario tasks that drive start/reset;
//   - checks of results against hand-computed values.
// -----------------------------------------------------------------------------
module tb_rt_fetch_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_rt;
    logic [31:0]  base_addr;
    logic         busy;
    logic         end_rt;
    logic         o_hit;
    logic [31:0]  o_t;
    logic [15:0]  o_tri_index;
    logic         avm_m0_read;
    logic [31:0]  avm_m0_address;
    logic [1:0]   avm_m0_byteenable;
    logic         avm_m0_waitrequest;
    logic [15:0]  avm_m0_readdata;
    logic         avm_m0_readdatavalid;
    logic [191:0] ray_o;
    logic [287:0] tri_o;
    logic         tri_valid;
    logic         tri_ready;
    logic         isect_valid;
    logic         isect_hit;
    logic [31:0]  isect_t;
    logic [31:0]  perf_stall;

    rt_fetch_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .start_rt             (start_rt),
        .base_addr            (base_addr),
        .busy                 (busy),
        .end_rt               (end_rt),
        .o_hit                (o_hit),
        .o_t                  (o_t),
        .o_tri_index          (o_tri_index),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .avm_m0_waitrequest   (avm_m0_waitrequest),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .ray_o                (ray_o),
        .tri_o                (tri_o),
        .tri_valid            (tri_valid),
        .tri_ready            (tri_ready),
        .isect_valid          (isect_valid),
        .isect_hit            (isect_hit),
        .isect_t              (isect_t),
        .perf_stall           (perf_stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory and model state
    logic [15:0]  mem [0:8191];
    logic [31:0]  addr_log[$];
    logic [31:0]  hs_w0[$];
    logic [31:0]  hs_w8[$];
    int           acc_cnt = 0;
    int           end_cnt = 0;
    bit           tv_seen = 0;
    bit           rsp_pend = 0;
    logic [31:0]  rsp_addr = '0;
    int           stall_at = -1;
    int           stall_left = 0;
    bit           stall_active = 0;
    logic [31:0]  stall_addr = '0;
    int           stall_err = 0;
    int           ready_hold = 0;
    bit           hold_active = 0;
    logic [287:0] tri_snap = '0;
    int           hold_err = 0;
    bit           hs_pend = 0;
    logic [287:0] hs_tri = '0;
    int           isect_wait = 0;
    int           tri_no = 0;
    bit           res_hit [0:2];
    logic [31:0]  res_t   [0:2];

    task automatic put_word(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[13:1]]          = w[15:0];
        mem[addr[13:1] + 13'd1]  = w[31:16];
    endtask

    task automatic load_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0;
        // Basic scene at 0x1000
        put_word(32'h1000, 32'h0000_0000);
        put_word(32'h1004, 32'h0000_0000);
        put_word(32'h1008, 32'h0001_0000);
        put_word(32'h100C, 32'h0000_0000);
        put_word(32'h1010, 32'h0000_0000);
        put_word(32'h1014, 32'hFFFF_0000);
        put_word(32'h1018, 32'd3);
        for (int t = 0; t < 3; t++)
            for (int w = 0; w < 9; w++)
                put_word(32'h101C + 32'h24 * t + 4 * w, 32'hA000_0000 | (t << 8) | w);
        // Scene at 0x2000: count word 0x0001_0000 -> zero in 16 index bits
        for (int w = 0; w < 6; w++) put_word(32'h2000 + 4 * w, 32'h1111_0000 + w);
        put_word(32'h2018, 32'h0001_0000);
        put_word(32'h201C, 32'hDEAD_BEEF);
    endtask

    // Slave + intersector model, everything on the falling edge.
    initial begin
        avm_m0_waitrequest   = 1'b0;
        avm_m0_readdata      = 16'h0;
        avm_m0_readdatavalid = 1'b0;
        tri_ready            = 1'b0;
        isect_valid          = 1'b0;
        isect_hit            = 1'b0;
        isect_t              = 32'h0;
        forever begin
            @(negedge clk);
            if (end_rt)    end_cnt++;
            if (tri_valid) tv_seen = 1;

            // Read data: one cycle after acceptance
            if (rsp_pend) begin
                avm_m0_readdatavalid = 1'b1;
                avm_m0_readdata      = mem[rsp_addr[13:1]];
                rsp_pend             = 0;
            end else begin
                avm_m0_readdatavalid = 1'b0;
                avm_m0_readdata      = 16'h0;
            end

            // Read requests, with optional stall of one chosen read
            avm_m0_waitrequest = 1'b0;
            if (stall_active && (!avm_m0_read || avm_m0_address != stall_addr))
                stall_err++;
            if (avm_m0_read) begin
                if (stall_left > 0 && acc_cnt == stall_at) begin
                    if (!stall_active) begin
                        stall_active = 1;
                        stall_addr   = avm_m0_address;
                    end
                    avm_m0_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    stall_active = 0;
                    addr_log.push_back(avm_m0_address);
                    acc_cnt++;
                    rsp_pend = 1;
                    rsp_addr = avm_m0_address;
                end
            end

            // Intersector result, two cycles after the handshake cycle
            isect_valid = 1'b0;
            isect_hit   = 1'b0;
            isect_t     = 32'h0;
            if (isect_wait > 0) begin
                isect_wait--;
                if (isect_wait == 0) begin
                    isect_valid = 1'b1;
                    isect_hit   = res_hit[tri_no % 3];
                    isect_t     = res_t[tri_no % 3];
                    tri_no++;
                end
            end
            if (hs_pend) begin
                hs_pend = 0;
                hs_w0.push_back(hs_tri[31:0]);
                hs_w8.push_back(hs_tri[287:256]);
                isect_wait = 2;
            end

            // Triangle handshake, with optional back-pressure
            if (hold_active && (!tri_valid || tri_o != tri_snap || avm_m0_read))
                hold_err++;
            tri_ready = 1'b0;
            if (tri_valid) begin
                if (ready_hold > 0) begin
                    if (!hold_active) begin
                        hold_active = 1;
                        tri_snap    = tri_o;
                    end
                    ready_hold--;
                end else begin
                    hold_active = 0;
                    tri_ready   = 1'b1;
                    hs_pend     = 1;
                    hs_tri      = tri_o;
                end
            end
        end
    end

    task automatic set_results(input bit h0, input logic [31:0] t0,
                               input bit h1, input logic [31:0] t1,
                               input bit h2, input logic [31:0] t2);
        res_hit[0] = h0; res_t[0] = t0;
        res_hit[1] = h1; res_t[1] = t1;
        res_hit[2] = h2; res_t[2] = t2;
    endtask

    // Starts a scene and waits (bounded) for end_rt. With poke set, a
    // second start to 0x2000 is pulsed mid-run and must be ignored.
    task automatic run_scene(input logic [31:0] base, input bit poke);
        bit got;
        acc_cnt = 0; addr_log.delete(); hs_w0.delete(); hs_w8.delete();
        tri_no = 0; end_cnt = 0; tv_seen = 0;
        @(negedge clk);
        base_addr = base;
        start_rt  = 1'b1;
        @(negedge clk);
        start_rt  = 1'b0;
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (i == 10) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL busy_mid: got %b want 1", busy);
                end
            end
            if (poke && i == 30) begin start_rt = 1'b1; base_addr = 32'h2000; end
            if (poke && i == 31) start_rt = 1'b0;
            if (end_cnt != 0) got = 1;
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL end_timeout: no end_rt for base %h", base);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; start_rt = 1'b0; base_addr = 32'h0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (end_rt !== 1'b0) begin bad++; $display("FAIL rst_end: got %b want 0", end_rt); end
        total++; if (o_hit !== 1'b0) begin bad++; $display("FAIL rst_hit: got %b want 0", o_hit); end
        total++; if (o_t !== 32'h7FFF_FFFF) begin bad++; $display("FAIL rst_t: got %h want 7fffffff", o_t); end
        total++; if (o_tri_index !== 16'h0) begin bad++; $display("FAIL rst_idx: got %h want 0", o_tri_index); end
        total++; if (avm_m0_read !== 1'b0) begin bad++; $display("FAIL rst_read: got %b want 0", avm_m0_read); end
        total++; if (avm_m0_byteenable !== 2'b11) begin bad++; $display("FAIL rst_be: got %b want 11", avm_m0_byteenable); end
        total++; if (tri_valid !== 1'b0) begin bad++; $display("FAIL rst_tv: got %b want 0", tri_valid); end
        total++; if (ray_o !== 192'h0 || tri_o !== 288'h0) begin bad++; $display("FAIL rst_data: ray/tri not zero"); end
        total++; if (perf_stall !== 32'h0) begin bad++; $display("FAIL rst_perf: got %0d want 0", perf_stall); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        set_results(1'b1, 32'd196608, 1'b1, 32'd65536, 1'b0, 32'd256);
        run_scene(32'h1000, 1'b0);
        total++; if (o_hit !== 1'b1) begin bad++; $display("FAIL basic_hit: got %b want 1", o_hit); end
        total++; if (o_t !== 32'd65536) begin bad++; $display("FAIL basic_t: got %h want 00010000", o_t); end
        total++; if (o_tri_index !== 16'd1) begin bad++; $display("FAIL basic_idx: got %0d want 1", o_tri_index); end
        total++; if (end_cnt != 1) begin bad++; $display("FAIL basic_endcnt: got %0d want 1", end_cnt); end
        total++; if (ray_o[95:64] !== 32'h0001_0000) begin bad++; $display("FAIL ray_w2: got %h want 00010000", ray_o[95:64]); end
        total++; if (ray_o[191:160] !== 32'hFFFF_0000) begin bad++; $display("FAIL ray_w5: got %h want ffff0000", ray_o[191:160]); end
        total++; if (hs_w0.size() != 3) begin bad++; $display("FAIL basic_hs: got %0d want 3", hs_w0.size()); end
        else begin
            total++; if (hs_w0[0] !== 32'hA000_0000) begin bad++; $display("FAIL tri0_w0: got %h want a0000000", hs_w0[0]); end
            total++; if (hs_w8[1] !== 32'hA000_0108) begin bad++; $display("FAIL tri1_w8: got %h want a0000108", hs_w8[1]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_addresses();
        total++;
        if (addr_log.size() != 68) begin
            bad++; $display("FAIL addr_count: got %0d want 68", addr_log.size());
        end else begin
            total++; if (addr_log[0]  !== 32'h1000) begin bad++; $display("FAIL addr_ray: got %h want 1000", addr_log[0]); end
            total++; if (addr_log[12] !== 32'h1018) begin bad++; $display("FAIL addr_cnt: got %h want 1018", addr_log[12]); end
            total++; if (addr_log[14] !== 32'h101C) begin bad++; $display("FAIL addr_tri0_first: got %h want 101c", addr_log[14]); end
            total++; if (addr_log[31] !== 32'h103E) begin bad++; $display("FAIL addr_tri0_last: got %h want 103e", addr_log[31]); end
            total++; if (addr_log[32] !== 32'h1040) begin bad++; $display("FAIL addr_tri1: got %h want 1040", addr_log[32]); end
        end
    endtask

    task automatic test_count_zero();
        set_results(1'b1, 32'd100, 1'b1, 32'd100, 1'b1, 32'd100);
        run_scene(32'h2000, 1'b0);
        total++; if (addr_log.size() != 14) begin bad++; $display("FAIL zero_reads: got %0d want 14", addr_log.size()); end
        total++; if (tv_seen) begin bad++; $display("FAIL zero_tv: got 1 want 0"); end
        total++; if (end_cnt != 1) begin bad++; $display("FAIL zero_endcnt: got %0d want 1", end_cnt); end
        total++; if (o_hit !== 1'b0) begin bad++; $display("FAIL zero_hit: got %b want 0", o_hit); end
        total++; if (o_t !== 32'h7FFF_FFFF) begin bad++; $display("FAIL zero_t: got %h want 7fffffff", o_t); end
        total++; if (o_tri_index !== 16'h0) begin bad++; $display("FAIL zero_idx: got %0d want 0", o_tri_index); end
    endtask

    task automatic test_waitrequest();
        set_results(1'b1, 32'd196608, 1'b1, 32'd65536, 1'b0, 32'd256);
        stall_at = 2; stall_left = 5; stall_err = 0;
        run_scene(32'h1000, 1'b0);
        total++; if (stall_left != 0) begin bad++; $display("FAIL wr_applied: got %0d left want 0", stall_left); end
        total++; if (stall_err != 0) begin bad++; $display("FAIL wr_stable: got %0d want 0 errors", stall_err); end
        total++; if (addr_log.size() < 3 || addr_log[2] !== 32'h1004) begin bad++; $display("FAIL wr_addr3: third read address wrong, want 1004"); end
        total++; if (o_hit !== 1'b1 || o_t !== 32'd65536 || o_tri_index !== 16'd1)
            begin bad++; $display("FAIL wr_result: got %b/%h/%0d want 1/00010000/1", o_hit, o_t, o_tri_index); end
`ifdef RT_FETCH_PERF_EN
        total++; if (perf_stall !== 32'd5) begin bad++; $display("FAIL wr_perf: got %0d want 5", perf_stall); end
`else
        total++; if (perf_stall !== 32'd0) begin bad++; $display("FAIL wr_perf: got %0d want 0", perf_stall); end
`endif
        stall_at = -1;
    endtask

    task automatic test_ready_hold();
        set_results(1'b1, 32'd196608, 1'b1, 32'd65536, 1'b0, 32'd256);
        ready_hold = 4; hold_err = 0;
        run_scene(32'h1000, 1'b0);
        total++; if (ready_hold != 0) begin bad++; $display("FAIL hold_applied: got %0d left want 0", ready_hold); end
        total++; if (hold_err != 0) begin bad++; $display("FAIL hold_stable: got %0d want 0 errors", hold_err); end
        total++; if (o_hit !== 1'b1 || o_t !== 32'd65536 || o_tri_index !== 16'd1)
            begin bad++; $display("FAIL hold_result: got %b/%h/%0d want 1/00010000/1", o_hit, o_t, o_tri_index); end
`ifdef RT_FETCH_PERF_EN
        total++; if (perf_stall !== 32'd4) begin bad++; $display("FAIL hold_perf: got %0d want 4", perf_stall); end
`else
        total++; if (perf_stall !== 32'd0) begin bad++; $display("FAIL hold_perf: got %0d want 0", perf_stall); end
`endif
    endtask

    // Negative t ignored; equal t keeps the earlier triangle.
    task automatic test_best_rule();
        set_results(1'b1, 32'hFFFF_FFFB, 1'b1, 32'h0002_0000, 1'b1, 32'h0002_0000);
        run_scene(32'h1000, 1'b0);
        total++; if (o_hit !== 1'b1) begin bad++; $display("FAIL best_hit: got %b want 1", o_hit); end
        total++; if (o_t !== 32'h0002_0000) begin bad++; $display("FAIL best_t: got %h want 00020000", o_t); end
        total++; if (o_tri_index !== 16'd1) begin bad++; $display("FAIL best_idx: got %0d want 1", o_tri_index); end
    endtask

    task automatic test_reset_mid();
        bit found;
        set_results(1'b1, 32'd196608, 1'b1, 32'd65536, 1'b0, 32'd256);
        acc_cnt = 0; addr_log.delete(); end_cnt = 0;
        @(negedge clk);
        base_addr = 32'h1000; start_rt = 1'b1;
        @(negedge clk);
        start_rt = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (avm_m0_read && acc_cnt >= 16) found = 1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL mid_reach_tri: never reached triangle fetch");
        end
        #2 reset = 1'b0;
        #1;
        total++; if (avm_m0_read !== 1'b0) begin bad++; $display("FAIL mid_read: got %b want 0", avm_m0_read); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        // Release while the late read data is on the bus
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        total++; if (ray_o !== 192'h0 || tri_o !== 288'h0) begin bad++; $display("FAIL mid_late_rdv: data changed in IDLE"); end
        total++; if (busy !== 1'b0 || avm_m0_read !== 1'b0) begin bad++; $display("FAIL mid_idle: busy=%b read=%b want 0/0", busy, avm_m0_read); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_restart_busy_start();
        set_results(1'b1, 32'd196608, 1'b1, 32'd65536, 1'b0, 32'd256);
        run_scene(32'h1000, 1'b1);
        total++; if (end_cnt != 1) begin bad++; $display("FAIL restart_endcnt: got %0d want 1", end_cnt); end
        total++; if (addr_log.size() != 68) begin bad++; $display("FAIL restart_reads: got %0d want 68", addr_log.size()); end
        total++; if (o_hit !== 1'b1 || o_t !== 32'd65536 || o_tri_index !== 16'd1)
            begin bad++; $display("FAIL restart_result: got %b/%h/%0d want 1/00010000/1", o_hit, o_t, o_tri_index); end
    endtask

    initial begin
        load_mem();
        test_reset();
        test_basic();
        test_addresses();
        test_count_zero();
        test_waitrequest();
        test_ready_hold();
        test_best_rule();
        test_reset_mid();
        test_restart_busy_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
